// File: rtl/dac_segment_encoder_if.sv
// Control and switch-array bus of the segmented DAC front end.
// The master drives power/code inputs; the slave (encoder) drives switch enables.
interface dac_segment_encoder_if;
   logic        pdb;
   logic        code_vld;
   logic [9:0]  code;
   logic        red_en;
   logic        ready;
   logic [16:0] sw_them;
   logic [5:0]  sw_bin;
   logic        sw_bin_red;
   logic [4:0]  dwa_ptr;

   modport master (
      output pdb, code_vld, code, red_en,
      input  ready, sw_them, sw_bin, sw_bin_red, dwa_ptr
   );

   modport slave (
      input  pdb, code_vld, code, red_en,
      output ready, sw_them, sw_bin, sw_bin_red, dwa_ptr
   );
endinterface

// File: rtl/dac_segment_encoder.sv
// Segmented DAC front end: 4-bit MSB count -> 17-unit thermometer pool, 6 binary LSBs,
// power-up settle sequencing. Define DAC_DWA_EN for data-weighted-averaging rotation.
module dac_segment_encoder #(
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic                        clk,
   input  logic                        rstb,
   dac_segment_encoder_if.slave        bus
);

   typedef enum logic [1:0] {ST_OFF, ST_SETTLE, ST_RUN} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t      state, state_nxt;
   logic [7:0]  settle_cnt, settle_cnt_nxt;
   logic        run;

   logic [9:0]  code_p0;
   logic        vld_p0;
   logic [3:0]  cnt;
   logic [16:0] them_nxt;
   logic [16:0] them_p1;
   logic [5:0]  bin_p1;
   logic        red_p1;

   function automatic logic [16:0] them_mask(input logic [3:0] n);
      return (17'd1 << n) - 17'd1;
   endfunction

`ifdef DAC_DWA_EN
   logic [4:0] ptr_p1;

   // Sum of pointer (<=16) and count (<=15) fits in 5 bits; a single subtract wraps it.
   function automatic logic [4:0] wrap17(input logic [4:0] sum);
      return (sum >= 5'd17) ? sum - 5'd17 : sum;
   endfunction

   function automatic logic [16:0] rotl17(input logic [16:0] v, input logic [4:0] p);
      logic [33:0] dbl;
      dbl = {v, v} << p;
      return dbl[33:17];
   endfunction
`endif

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state      <= ST_OFF;
         settle_cnt <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      settle_cnt_nxt = settle_cnt;
      case (state)
         ST_OFF: begin
            if (bus.pdb) begin
               state_nxt      = ST_SETTLE;
               settle_cnt_nxt = '0;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state_nxt = ST_RUN;
            else                           settle_cnt_nxt = settle_cnt + 8'd1;
         end
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_OFF;
      endcase
      if (!bus.pdb) begin
         state_nxt      = ST_OFF;
         settle_cnt_nxt = '0;
      end
   end

   // A falling pdb clears the datapath on the same edge that drops the FSM to OFF.
   assign run = (state == ST_RUN) && bus.pdb;
   assign cnt = code_p0[9:6];

`ifdef DAC_DWA_EN
   assign them_nxt = rotl17(them_mask(cnt), ptr_p1);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)                 ptr_p1 <= '0;
      else if (!run)             ptr_p1 <= '0;
      else if (vld_p0)           ptr_p1 <= wrap17(ptr_p1 + {1'b0, cnt});
   end

   assign bus.dwa_ptr = ptr_p1;
`else
   assign them_nxt    = them_mask(cnt);
   assign bus.dwa_ptr = '0;
`endif

   // stage p0: code capture
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         code_p0 <= '0;
         vld_p0  <= 1'b0;
      end else if (!run) begin
         code_p0 <= '0;
         vld_p0  <= 1'b0;
      end else begin
         vld_p0 <= bus.code_vld;
         if (bus.code_vld) code_p0 <= bus.code;
      end
   end

   // stage p1: switch enables
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         them_p1 <= '0;
         bin_p1  <= '0;
         red_p1  <= 1'b0;
      end else if (!run) begin
         them_p1 <= '0;
         bin_p1  <= '0;
         red_p1  <= 1'b0;
      end else if (vld_p0) begin
         them_p1 <= them_nxt;
         bin_p1  <= code_p0[5:0];
         red_p1  <= bus.red_en & code_p0[0];
      end
   end

   assign bus.ready      = (state == ST_RUN);
   assign bus.sw_them    = them_p1;
   assign bus.sw_bin     = bin_p1;
   assign bus.sw_bin_red = red_p1;

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Self-checking bench for dac_segment_encoder: directed vector table, power sequencing,
// and randomized streaming against a behavioural model (honours DAC_DWA_EN).
module tb_dac_segment_encoder;

   typedef struct {
      logic [9:0]  code;
      logic        red;
      logic [16:0] them;
      logic [5:0]  bin;
      logic        bred;
      logic [4:0]  ptr;
   } vec_t;

   logic clk;
   logic rstb;
   int   nvec;
   int   nfail;

   dac_segment_encoder_if bus ();

   dac_segment_encoder #(.SETTLE_CYCLES(16)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // behavioural model state
   int          m_ptr;
   logic [16:0] m_them;
   logic [5:0]  m_bin;
   logic        m_red;
   logic        pend_vld;
   logic [9:0]  pend_code;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // cnt units starting at unit p, wrapping modulo 17; fixed mapping keeps p at 0
   function automatic logic [16:0] ref_them(input int n, input int p);
      logic [16:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r[(p + k) % 17] = 1'b1;
      return r;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      int n;
      if (pend_vld) begin
         n      = int'(pend_code[9:6]);
         m_them = ref_them(n, m_ptr);
`ifdef DAC_DWA_EN
         m_ptr  = (m_ptr + n) % 17;
`endif
         m_bin  = pend_code[5:0];
         m_red  = bus.red_en & pend_code[0];
      end
      pend_vld  = bus.code_vld;
      pend_code = bus.code;
   endtask

   task automatic apply(input logic [9:0] c, input logic r);
      bus.code_vld = 1'b1;
      bus.code     = c;
      bus.red_en   = r;
      tick();
      bus.code_vld = 1'b0;
      tick();
   endtask

   // Count edges until ready; codes offered early in SETTLE must not reach the switches.
   task automatic run_settle(output int edges, output logic leak);
      edges = 0;
      leak  = 1'b0;
      while (!bus.ready && edges < 40) begin
         if (edges < 10) begin
            bus.code_vld = 1'b1;
            bus.code     = 10'h3FF;
            bus.red_en   = 1'b1;
         end else begin
            bus.code_vld = 1'b0;
         end
         tick();
         edges++;
         if (bus.sw_them != 17'd0 || bus.sw_bin != 6'd0 || bus.sw_bin_red || bus.dwa_ptr != 5'd0)
            leak = 1'b1;
      end
      bus.code_vld = 1'b0;
      bus.red_en   = 1'b0;
   endtask

   vec_t        tbl [5];
   int          edges;
   logic        leak;
   logic [16:0] h_them;
   logic [5:0]  h_bin;
   logic [4:0]  h_ptr;
   logic [16:0] lat_them;
   logic [4:0]  lat_ptr;

   initial begin
      nvec = 0;
      nfail = 0;

`ifdef DAC_DWA_EN
      tbl[0] = '{10'h0EA, 1'b0, 17'h00007, 6'h2A, 1'b0, 5'd3};
      tbl[1] = '{10'h3C0, 1'b0, 17'h1FFF9, 6'h00, 1'b0, 5'd1};
      tbl[2] = '{10'h000, 1'b1, 17'h00000, 6'h00, 1'b0, 5'd1};
      tbl[3] = '{10'h001, 1'b1, 17'h00000, 6'h01, 1'b1, 5'd1};
      tbl[4] = '{10'h001, 1'b0, 17'h00000, 6'h01, 1'b0, 5'd1};
      lat_them = 17'h0003E;
      lat_ptr  = 5'd6;
`else
      tbl[0] = '{10'h0EA, 1'b0, 17'h00007, 6'h2A, 1'b0, 5'd0};
      tbl[1] = '{10'h3C0, 1'b0, 17'h07FFF, 6'h00, 1'b0, 5'd0};
      tbl[2] = '{10'h000, 1'b1, 17'h00000, 6'h00, 1'b0, 5'd0};
      tbl[3] = '{10'h001, 1'b1, 17'h00000, 6'h01, 1'b1, 5'd0};
      tbl[4] = '{10'h001, 1'b0, 17'h00000, 6'h01, 1'b0, 5'd0};
      lat_them = 17'h0001F;
      lat_ptr  = 5'd0;
`endif

      // reset and power-up
      rstb         = 1'b0;
      bus.pdb      = 1'b1;
      bus.code_vld = 1'b0;
      bus.code     = '0;
      bus.red_en   = 1'b0;
      #2;
      check("rst_ready",   17'(bus.ready),      17'd0);
      check("rst_sw_them", bus.sw_them,         17'd0);
      check("rst_sw_bin",  17'(bus.sw_bin),     17'd0);
      check("rst_red",     17'(bus.sw_bin_red), 17'd0);
      check("rst_ptr",     17'(bus.dwa_ptr),    17'd0);
      repeat (3) @(posedge clk);
      #2;
      rstb = 1'b1;
      run_settle(edges, leak);
      check("pwrup_ready_edge", 17'(edges), 17'd17);
      check("pwrup_settle_leak", 17'(leak), 17'd0);

      // directed vectors from pointer 0
      for (int i = 0; i < 5; i++) begin
         apply(tbl[i].code, tbl[i].red);
         check($sformatf("vec%0d_sw_them", i), bus.sw_them,         tbl[i].them);
         check($sformatf("vec%0d_sw_bin", i),  17'(bus.sw_bin),     17'(tbl[i].bin));
         check($sformatf("vec%0d_red", i),     17'(bus.sw_bin_red), 17'(tbl[i].bred));
         check($sformatf("vec%0d_ptr", i),     17'(bus.dwa_ptr),    17'(tbl[i].ptr));
      end

      // two-cycle latency: nothing changes after the capture edge
      bus.code_vld = 1'b1;
      bus.code     = 10'h155;
      tick();
      bus.code_vld = 1'b0;
      check("lat_early_sw_bin",  17'(bus.sw_bin), 17'h01);
      check("lat_early_sw_them", bus.sw_them,     17'd0);
      tick();
      check("lat_sw_bin",  17'(bus.sw_bin),  17'h15);
      check("lat_sw_them", bus.sw_them,      lat_them);
      check("lat_ptr",     17'(bus.dwa_ptr), 17'(lat_ptr));

      // hold while code_vld is low
      h_them = bus.sw_them;
      h_bin  = bus.sw_bin;
      h_ptr  = bus.dwa_ptr;
      for (int i = 0; i < 5; i++) begin
         bus.code = 10'($urandom_range(0, 1023));
         tick();
         check($sformatf("hold%0d_sw_them", i), bus.sw_them,      lat_them);
         check($sformatf("hold%0d_sw_bin", i),  17'(bus.sw_bin),  17'(h_bin));
         check($sformatf("hold%0d_ptr", i),     17'(bus.dwa_ptr), 17'(h_ptr));
      end
      if (h_them !== lat_them) check("hold_base", h_them, lat_them);

      // power-down mid-stream discards the in-flight code
      bus.code_vld = 1'b1;
      bus.code     = 10'h3FF;
      bus.red_en   = 1'b1;
      tick();
      bus.pdb = 1'b0;
      tick();
      check("pd_sw_them", bus.sw_them,         17'd0);
      check("pd_sw_bin",  17'(bus.sw_bin),     17'd0);
      check("pd_red",     17'(bus.sw_bin_red), 17'd0);
      check("pd_ptr",     17'(bus.dwa_ptr),    17'd0);
      check("pd_ready",   17'(bus.ready),      17'd0);
      tick();
      check("pd_hold_sw_them", bus.sw_them, 17'd0);
      bus.pdb = 1'b1;
      run_settle(edges, leak);
      check("repwr_ready_edge",  17'(edges), 17'd17);
      check("repwr_settle_leak", 17'(leak),  17'd0);

      // randomized streaming against the model
      m_ptr     = 0;
      m_them    = '0;
      m_bin     = '0;
      m_red     = 1'b0;
      pend_vld  = 1'b0;
      pend_code = '0;
      for (int i = 0; i < 300; i++) begin
         bus.code_vld = ($urandom_range(0, 3) != 0);
         bus.code     = 10'($urandom_range(0, 1023));
         bus.red_en   = 1'($urandom_range(0, 1));
         model_edge();
         tick();
         check($sformatf("rnd%0d_sw_them", i), bus.sw_them,         m_them);
         check($sformatf("rnd%0d_sw_bin", i),  17'(bus.sw_bin),     17'(m_bin));
         check($sformatf("rnd%0d_red", i),     17'(bus.sw_bin_red), 17'(m_red));
         check($sformatf("rnd%0d_ptr", i),     17'(bus.dwa_ptr),    17'(m_ptr));
      end
      check("rnd_ready", 17'(bus.ready), 17'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
